// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the parity-bit rule used by
// both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned PARITY_MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Expected parity bit: parity_type=0 -> ~^data, parity_type=1 -> ^data.
    function automatic logic parity_bit(input logic [PARITY_MAX_W-1:0] data,
                                        input logic                    parity_type);
        return parity_type ? (^data) : (~^data);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect on the
// synchronized value.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall_c
);

    logic meta;
    logic rx_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            meta    <= rx;
            rx_s    <= meta;
            rx_prev <= rx_s;
        end
    end

    assign fall_c = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with optional parity, framing/overrun flags and a
// valid/ready output. Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 bit voting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned Data_Width   = 8,
    parameter int unsigned OverSampling = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  parity_en,
    input  logic                  parity_type,
    input  logic                  rx_ready,
    output logic [Data_Width-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned CNT_W = $clog2(OverSampling);
    localparam int unsigned BIT_W = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam int unsigned MID   = OverSampling / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned DECIDE = MID + 1;
`else
    localparam int unsigned DECIDE = MID;
`endif

    logic rx_s;
    logic fall_c;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .rx_s   (rx_s),
        .fall_c (fall_c)
    );

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
    logic [Data_Width-1:0]   shift_q, shift_d;
    logic                    par_err_q, par_err_d;
    logic                    par_en_q, par_en_d;
    logic                    par_type_q, par_type_d;
    logic [Data_Width-1:0]   rx_data_d;
    logic                    rx_valid_d, parity_err_d, frame_err_d, overrun_d;
    logic                    sample_c, last_c, bit_c, done_c, hs_c;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic                    maj_a_q, maj_a_d, maj_b_q, maj_b_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            maj_a_q    <= 1'b1;
            maj_b_q    <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
            overrun    <= overrun_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
            maj_a_q    <= maj_a_d;
            maj_b_q    <= maj_b_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = last_c ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        done_c     = 1'b0;
        sample_c   = (cnt_q == CNT_W'(DECIDE));
        last_c     = (cnt_q == CNT_W'(OverSampling - 1));
`ifdef UART_RX_MAJORITY_VOTE_EN
        maj_a_d    = (cnt_q == CNT_W'(MID - 1)) ? rx_s : maj_a_q;
        maj_b_d    = (cnt_q == CNT_W'(MID)) ? rx_s : maj_b_q;
        bit_c      = (maj_a_q & maj_b_q) | (maj_a_q & rx_s) | (maj_b_q & rx_s);
`else
        bit_c      = rx_s;
`endif
        cnt_d      = last_c ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall_c) begin
                    state_d    = START;
                    bit_idx_d  = '0;
                    par_err_d  = 1'b0;
                    par_en_d   = parity_en;
                    par_type_d = parity_type;
                end
            end
            START: begin
                if (sample_c && bit_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (last_c) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                // LSB arrives first, so shift in at the top.
                if (sample_c) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[Data_Width-1]   = bit_c;
                end
                if (last_c) begin
                    if (bit_idx_q == BIT_W'(Data_Width - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        cnt_d   = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (sample_c)
                    par_err_d = bit_c ^ parity_bit(PARITY_MAX_W'(shift_q), par_type_q);
                if (last_c) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
            end
            STOP: begin
                if (sample_c) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output holding register: load, drop (overrun) or consume.
    always_comb begin
        rx_data_d    = rx_data;
        rx_valid_d   = rx_valid;
        parity_err_d = parity_err;
        frame_err_d  = frame_err;
        overrun_d    = overrun;
        hs_c         = rx_valid & rx_ready;

        if (hs_c)
            overrun_d = 1'b0;

        if (done_c) begin
            if (!rx_valid || rx_ready) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                parity_err_d = par_en_q & par_err_q;
                frame_err_d  = ~bit_c;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (hs_c) begin
            rx_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (Data_Width=8, OverSampling=16).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       parity_en;
    logic       parity_type;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int seen     = 0;

    always #5 clk = ~clk;

    uart_rx #(.Data_Width(8), .OverSampling(OS)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par,
                              input logic pbit, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (with_par) send_bit(pbit);
        send_bit(stop);
    endtask

    task automatic handshake();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        rx          = 1'b1;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        rx_ready    = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data",   32'(rx_data),    32'h0);
        check("rst_valid",  32'(rx_valid),   32'h0);
        check("rst_perr",   32'(parity_err), 32'h0);
        check("rst_ferr",   32'(frame_err),  32'h0);
        check("rst_ovr",    32'(overrun),    32'h0);
        reset = 1'b0;
        idle_bits(2);

        // 0xA5 has four ones: odd-style parity bit is 1
        parity_en = 1'b1; parity_type = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        check("a5_valid", 32'(rx_valid),   32'h1);
        check("a5_data",  32'(rx_data),    32'hA5);
        check("a5_perr",  32'(parity_err), 32'h0);
        check("a5_ferr",  32'(frame_err),  32'h0);
        check("a5_ovr",   32'(overrun),    32'h0);
        handshake();
        check("a5_consumed", 32'(rx_valid), 32'h0);
        check("a5_hold",     32'(rx_data),  32'hA5);
        idle_bits(1);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check("a5bad_data", 32'(rx_data),    32'hA5);
        check("a5bad_perr", 32'(parity_err), 32'h1);
        handshake();
        idle_bits(1);

        parity_en = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("3c_valid", 32'(rx_valid),   32'h1);
        check("3c_data",  32'(rx_data),    32'h3C);
        check("3c_perr",  32'(parity_err), 32'h0);
        handshake();
        idle_bits(1);

        // 0x07 has three ones: even-style parity bit is 1
        parity_en = 1'b1; parity_type = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        check("07_data", 32'(rx_data),    32'h07);
        check("07_perr", 32'(parity_err), 32'h0);
        handshake();
        idle_bits(1);

        parity_en = 1'b0; parity_type = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check("55_data", 32'(rx_data),   32'h55);
        check("55_ferr", 32'(frame_err), 32'h1);
        handshake();
        rx = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 * OS; i++) begin
            @(negedge clk);
            if (rx_valid) seen++;
        end
        check("low_no_valid", 32'(seen), 32'h0);
        idle_bits(2);
        check("low_released", 32'(rx_valid), 32'h0);

        rx = 1'b0;
        repeat (6) @(negedge clk);
        idle_bits(3);
        check("glitch_valid", 32'(rx_valid),     32'h0);
        check("glitch_idle",  32'(dut.state_q),  32'(IDLE));

        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        check("b2b_valid", 32'(rx_valid), 32'h1);
        check("b2b_data",  32'(rx_data),  32'h11);
        check("b2b_ovr",   32'(overrun),  32'h1);
        handshake();
        check("b2b_consumed", 32'(rx_valid), 32'h0);
        check("b2b_ovr_clr",  32'(overrun),  32'h0);
        idle_bits(1);

        // 0x66 has four ones: correct parity bit would be 1
        parity_en = 1'b1; parity_type = 1'b0;
        send_frame(8'h66, 1'b1, 1'b0, 1'b0);
        idle_bits(1);
        check("66_data", 32'(rx_data),    32'h66);
        check("66_perr", 32'(parity_err), 32'h1);
        check("66_ferr", 32'(frame_err),  32'h1);
        parity_en = 1'b0;
        send_frame(8'h99, 1'b0, 1'b0, 1'b1);
        check("99_dropped", 32'(overrun), 32'h1);
        idle_bits(1);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i));
        rx = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_data_state", 32'(dut.state_q), 32'(DATA));
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_data",  32'(rx_data),     32'h0);
        check("mrst_valid", 32'(rx_valid),    32'h0);
        check("mrst_perr",  32'(parity_err),  32'h0);
        check("mrst_ferr",  32'(frame_err),   32'h0);
        check("mrst_ovr",   32'(overrun),     32'h0);
        check("mrst_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;
        idle_bits(2);
        check("mrst_no_frame", 32'(rx_valid), 32'h0);

        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        check("81_valid", 32'(rx_valid),   32'h1);
        check("81_data",  32'(rx_data),    32'h81);
        check("81_perr",  32'(parity_err), 32'h0);
        check("81_ferr",  32'(frame_err),  32'h0);
        idle_bits(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Data_Width, default 8, number of data bits per frame.
REQ-002 OverSampling, default 16, clk cycles per bit period; SHALL be even and >= 8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idle high.
REQ-006 parity_en  input  1  1: a parity bit follows the data bits; 0: no parity bit.
REQ-007 parity_type  input  1  parity encoding select (see REQ-016).
REQ-008 rx_data  output  Data_Width  last received data word.
REQ-009 rx_valid  output  1  rx_data/parity_err/frame_err hold an unconsumed frame.
REQ-010 rx_ready  input  1  consumer accepts the frame in any cycle where rx_valid && rx_ready.
REQ-011 parity_err  output  1  parity mismatch on the frame in rx_data.
REQ-012 frame_err  output  1  stop bit sampled low on the frame in rx_data.
REQ-013 overrun  output  1  sticky: a completed frame was dropped.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; "rx_s" below is the synchronizer output.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a bit counter SHALL run 0..OverSampling-1, reset to 0 on every state entry, and wrap at OverSampling-1.
REQ-016 The expected parity bit SHALL be ~^data when parity_type=0 and ^data when parity_type=1, so that it matches the team's transmitter.
REQ-017 IDLE: a falling edge on rx_s (previous 1, current 0) SHALL move the FSM to START; a line held low SHALL NOT trigger a start.
REQ-018 START: sample at count OverSampling/2; sample 1 -> IDLE (false start, nothing reported); sample 0 -> continue; at count OverSampling-1 -> DATA.
REQ-019 DATA: sample each bit at count OverSampling/2 and shift it into the MSB of the shift register (LSB first on the line).
REQ-020 DATA: after bit Data_Width-1, at count OverSampling-1 go to PARITY if parity_en=1, else to STOP.
REQ-021 PARITY: sample at mid-bit and store the mismatch vs REQ-016; at count OverSampling-1 -> STOP.
REQ-022 STOP: at the mid-bit sample the frame SHALL complete and the FSM SHALL return to IDLE immediately, so back-to-back frames are received.
REQ-023 Completion latency: rx_valid, rx_data, parity_err and frame_err SHALL update on the clk edge after the stop-bit sample.
REQ-024 Completion rules:
- rx_valid=0, or rx_valid && rx_ready in the same cycle: load the new frame, rx_valid=1.
- Otherwise: discard the new frame, keep the old one, set overrun.
REQ-025 rx_valid && rx_ready with no completion SHALL clear rx_valid on the next cycle; rx_data SHALL hold its value.
REQ-026 overrun SHALL be cleared by the first handshake after it was set, unless a drop occurs in that same cycle.
REQ-027 parity_err SHALL be 0 when parity_en=0; parity_en and parity_type SHALL be sampled on START entry and held for the frame.

Reset
REQ-028 While reset=1: FSM=IDLE, counters=0, synchronizer=1, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without asserting rx_valid; after release, reception SHALL begin only at the next falling edge.

Configuration
REQ-030 Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of samples at counts OverSampling/2-1, OverSampling/2 and OverSampling/2+1; the decision and completion (REQ-018, REQ-022) occur at count OverSampling/2+1, adding one cycle of latency.
- Undefined: a single sample at OverSampling/2.

Structure
REQ-031 Shared package uart_pkg SHALL hold state_t and a parity-bit function implementing REQ-016, shared with the transmitter.
REQ-032 Sub-module uart_rx_sync SHALL implement the synchronizer and falling-edge detect.

Verification (Data_Width=8, OverSampling=16)
REQ-033 Frame 0xA5, parity_en=1, parity_type=0, parity bit 1, stop 1 -> rx_data=0xA5, rx_valid=1, parity_err=0, frame_err=0.
REQ-034 Same frame with parity bit 0 -> rx_data=0xA5, parity_err=1; parity_en=0 with no parity bit, frame 0x3C -> rx_data=0x3C, parity_err=0.
REQ-035 Frame 0x55 with stop bit 0 -> frame_err=1; line then held low for 40 bit periods -> no further rx_valid until a new falling edge.
REQ-036 rx low for 6 cycles, then high -> FSM returns to IDLE, rx_valid remains 0.
REQ-037 Two back-to-back frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun=1; one handshake -> rx_valid=0, overrun=0.
REQ-038 Reset pulse during DATA bit 4 -> all outputs 0; next clean frame 0x81 -> rx_data=0x81.
